// File: rtl/fifo_pop_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pop_ctrl_pkg
// Shared definitions for the FIFO pop controller:
//   - default data and counter widths
//   - read FSM state encoding (IDLE: no read in flight, WAIT: one in flight)
//   - slot_free(): decides whether one more FIFO read fits in the buffer
// ---------------------------------------------------------------------------
package fifo_pop_ctrl_pkg;

    localparam int DATA_WIDTH_DEF = 4;
    localparam int CNT_WIDTH_DEF  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } rd_state_e;

    // True when buffered words plus the in-flight word leave room for one more.
    // A word leaving downstream on this same edge frees its slot, so a new read
    // may be issued in that cycle; this is what sustains one word per cycle.
    function automatic logic slot_free(input logic [1:0] occ,
                                       input logic       inflight,
                                       input logic       accept);
        logic [2:0] used_s;
        logic [2:0] limit_s;
        used_s  = {1'b0, occ} + {2'b00, inflight};
        limit_s = 3'd2 + {2'b00, accept};
        return (used_s < limit_s);
    endfunction

endpackage

// File: rtl/fifo_pop_ctrl_skid_buf2.sv
// ---------------------------------------------------------------------------
// skid_buf2
// Two-entry in-order output buffer.
//   clk, rst : clock, synchronous active-high reset (clears contents to 0)
//   push     : capture din at the rising edge
//   pop      : drop the oldest word at the rising edge
//   din      : word to capture
//   dout     : oldest buffered word (holds its value until popped)
//   count    : number of buffered words (0..2)
// A push and pop on the same edge keeps the count and preserves order.
// ---------------------------------------------------------------------------
module skid_buf2 import fifo_pop_ctrl_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] head_r;
    logic [DATA_WIDTH-1:0] tail_r;
    logic [1:0]            count_r;
    logic [DATA_WIDTH-1:0] head_nxt_s;
    logic [DATA_WIDTH-1:0] tail_nxt_s;
    logic [1:0]            count_nxt_s;
    logic                  pop_s;
    logic                  push_s;

    // Next-state for the two slots: head is always the oldest word.
    always_comb begin
        pop_s       = pop && (count_r != 2'd0);
        push_s      = push && ((count_r != 2'd2) || pop_s);
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b01: begin
                head_nxt_s  = tail_r;
                count_nxt_s = count_r - 2'd1;
            end
            2'b10: begin
                if (count_r == 2'd0) begin
                    head_nxt_s = din;
                end else begin
                    tail_nxt_s = din;
                end
                count_nxt_s = count_r + 2'd1;
            end
            2'b11: begin
                if (count_r == 2'd1) begin
                    head_nxt_s = din;
                end else begin
                    head_nxt_s = tail_r;
                    tail_nxt_s = din;
                end
            end
            default: begin
                count_nxt_s = count_r;
            end
        endcase
    end

    // Slot and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {DATA_WIDTH{1'b0}};
            tail_r  <= {DATA_WIDTH{1'b0}};
            count_r <= 2'd0;
        end else begin
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    assign dout  = head_r;
    assign count = count_r;

endmodule

// File: rtl/fifo_pop_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_pop_ctrl
// Drains a FIFO with one-cycle read latency into a 2-entry output buffer and
// presents words downstream with a valid/ready handshake.
//   clk, rst   : clock, synchronous active-high reset
//   en         : allow new FIFO reads
//   buf_empty  : FIFO empty flag (registered in the FIFO)
//   buf_out    : FIFO read data, valid the cycle after a sampled rd_en
//   rd_en      : FIFO pop request (combinational)
//   data_out   : oldest buffered word
//   valid_out  : data_out holds a word
//   ready_in   : downstream accepts data_out when valid_out is high
//   pop_count  : words delivered downstream since reset (wraps)
// ---------------------------------------------------------------------------
module fifo_pop_ctrl import fifo_pop_ctrl_pkg::*; #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  buf_empty,
    input  logic [DATA_WIDTH-1:0] buf_out,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_in,
    output logic [CNT_WIDTH-1:0]  pop_count
);

    rd_state_e            state_r;
    rd_state_e            state_nxt_s;
    logic [1:0]           occ_s;
    logic                 accept_s;
    logic                 capture_s;
    logic [CNT_WIDTH-1:0] pop_count_r;

    assign valid_out = (occ_s != 2'd0);
    assign accept_s  = valid_out && ready_in;
    // The word requested on the previous edge is on buf_out while in WAIT.
    assign capture_s = (state_r == WAIT);

    // FIFO read request; never while in reset or while the FIFO is empty.
    always_comb begin
        rd_en = 1'b0;
        if (!rst && en && !buf_empty) begin
            rd_en = slot_free(occ_s, capture_s, accept_s);
        end else begin
            rd_en = 1'b0;
        end
    end

    // Read FSM next state: WAIT exactly when a read was just issued.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (rd_en) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (rd_en) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Read FSM state register; reset drops any word still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Downstream transfer counter, wraps naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_count_r <= {CNT_WIDTH{1'b0}};
        end else if (accept_s) begin
            pop_count_r <= pop_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            pop_count_r <= pop_count_r;
        end
    end

    assign pop_count = pop_count_r;

    skid_buf2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf2 (
        .clk   (clk),
        .rst   (rst),
        .push  (capture_s),
        .pop   (accept_s),
        .din   (buf_out),
        .dout  (data_out),
        .count (occ_s)
    );

endmodule

// File: tb/tb_fifo_pop_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_pop_ctrl
// Bench for fifo_pop_ctrl: a queue-based FIFO environment drives buf_empty /
// buf_out, and a queue-level reference model predicts rd_en, valid_out,
// data_out and pop_count every cycle. Directed scenarios are followed by a
// randomized run.
// ---------------------------------------------------------------------------
module tb_fifo_pop_ctrl;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          buf_empty;
    logic [DW-1:0] buf_out;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          ready_in;
    logic [CW-1:0] pop_count;

    always #5 clk = ~clk;

    fifo_pop_ctrl #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .buf_empty (buf_empty),
        .buf_out   (buf_out),
        .rd_en     (rd_en),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ready_in  (ready_in),
        .pop_count (pop_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // FIFO environment contents
    logic [DW-1:0] fifo_q[$];

    // Reference model: words held downstream-side, plus one word in flight
    logic [DW-1:0] mq[$];
    bit            m_infl      = 1'b0;
    logic [DW-1:0] m_infl_val  = '0;
    int            m_cnt       = 0;
    bit            m_known     = 1'b0;
    bit            m_dout_zero = 1'b0;

    int            cyc = 0;
    logic [DW-1:0] deliv[$];
    int            deliv_cyc[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic load(input logic [DW-1:0] v);
        fifo_q.push_back(v);
        buf_empty = 1'b0;
    endtask

    // One clock cycle: apply inputs, check at the falling edge, then advance
    // the FIFO environment and the model just after the rising edge.
    task automatic tick(input bit t_rst, input bit t_en, input bit t_rdy,
                        input bit t_push, input logic [DW-1:0] t_val);
        bit acc;
        bit exp_rd;
        bit dut_rd;
        rst      = t_rst;
        en       = t_en;
        ready_in = t_rdy;
        @(negedge clk);
        acc    = (mq.size() != 0) && t_rdy;
        exp_rd = !t_rst && t_en && !buf_empty &&
                 ((mq.size() + int'(m_infl)) < (2 + int'(acc)));
        if (m_known || t_rst) begin
            check_eq("rd_en", 32'(rd_en), 32'(exp_rd));
        end
        if (m_known) begin
            check_eq("valid_out", 32'(valid_out), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                check_eq("data_out", 32'(data_out), 32'(mq[0]));
            end else if (m_dout_zero) begin
                check_eq("data_out_rst", 32'(data_out), 32'd0);
            end
            check_eq("pop_count", 32'(pop_count), 32'(m_cnt % (1 << CW)));
        end
        if (valid_out && t_rdy && !t_rst) begin
            deliv.push_back(data_out);
            deliv_cyc.push_back(cyc);
        end
        dut_rd = rd_en;
        @(posedge clk);
        #1;
        cyc++;
        if (dut_rd && fifo_q.size() > 0) begin
            buf_out = fifo_q.pop_front();
        end
        if (t_push) begin
            fifo_q.push_back(t_val);
        end
        buf_empty = (fifo_q.size() == 0);
        if (t_rst) begin
            mq.delete();
            m_infl      = 1'b0;
            m_cnt       = 0;
            m_known     = 1'b1;
            m_dout_zero = 1'b1;
        end else begin
            if (acc) begin
                void'(mq.pop_front());
                m_cnt++;
            end
            if (m_infl) begin
                mq.push_back(m_infl_val);
                m_dout_zero = 1'b0;
            end
            m_infl     = exp_rd;
            m_infl_val = buf_out;
        end
    endtask

    task automatic clear_log();
        deliv.delete();
        deliv_cyc.delete();
    endtask

    initial begin
        int start;
        logic [DW-1:0] val;
        rst       = 1'b1;
        en        = 1'b1;
        ready_in  = 1'b1;
        buf_empty = 1'b1;
        buf_out   = '0;

        // Reset held two cycles with a non-empty FIFO
        load(8'd7);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        check_eq("rst_valid", 32'(valid_out), 32'd0);
        check_eq("rst_count", 32'(pop_count), 32'd0);
        repeat (5) tick(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);

        // Streaming 1,2,3
        tick(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        clear_log();
        start = cyc;
        load(8'd1); load(8'd2); load(8'd3);
        repeat (8) tick(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        check_eq("stream_n", 32'(deliv.size()), 32'd3);
        if (deliv.size() == 3) begin
            for (int i = 0; i < 3; i++) check_eq("stream_data", 32'(deliv[i]), 32'(i + 1));
            check_eq("stream_lat", 32'(deliv_cyc[0]), 32'(start + 2));
            check_eq("stream_span", 32'(deliv_cyc[2] - deliv_cyc[0]), 32'd2);
        end
        check_eq("stream_cnt", 32'(pop_count), 32'd3);
        check_eq("stream_rd_idle", 32'(rd_en), 32'd0);

        // Backpressure 10..13
        tick(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        clear_log();
        for (int i = 10; i < 14; i++) load(8'(i));
        repeat (6) tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        check_eq("bp_valid", 32'(valid_out), 32'd1);
        check_eq("bp_hold", 32'(data_out), 32'd10);
        check_eq("bp_rd", 32'(rd_en), 32'd0);
        check_eq("bp_fifo_left", 32'(fifo_q.size()), 32'd2);
        repeat (8) tick(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        check_eq("bp_n", 32'(deliv.size()), 32'd4);
        if (deliv.size() == 4) begin
            for (int i = 0; i < 4; i++) check_eq("bp_data", 32'(deliv[i]), 32'(10 + i));
            check_eq("bp_span", 32'(deliv_cyc[3] - deliv_cyc[0]), 32'd3);
        end

        // en gating
        tick(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        clear_log();
        load(8'd5);
        repeat (4) tick(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
        check_eq("en_rd", 32'(rd_en), 32'd0);
        check_eq("en_valid", 32'(valid_out), 32'd0);
        start = cyc;
        repeat (5) tick(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        check_eq("en_n", 32'(deliv.size()), 32'd1);
        if (deliv.size() == 1) begin
            check_eq("en_data", 32'(deliv[0]), 32'd5);
            check_eq("en_lat", 32'(deliv_cyc[0]), 32'(start + 2));
        end

        // Simultaneous push / capture / accept over 16 words
        tick(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        clear_log();
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 1'b1, 1'b1, 8'(20 + i));
        repeat (6) tick(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        check_eq("sim_n", 32'(deliv.size()), 32'd16);
        if (deliv.size() == 16) begin
            for (int i = 0; i < 16; i++) check_eq("sim_data", 32'(deliv[i]), 32'(20 + i));
            check_eq("sim_span", 32'(deliv_cyc[15] - deliv_cyc[0]), 32'd15);
        end

        // Counter wrap: 17 transfers on a 4-bit counter
        tick(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        clear_log();
        for (int i = 0; i < 17; i++) load(8'(30 + i));
        repeat (25) tick(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        check_eq("wrap_n", 32'(deliv.size()), 32'd17);
        check_eq("wrap_cnt", 32'(pop_count), 32'd1);

        // Reset while a read is in flight
        tick(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        clear_log();
        load(8'd99);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        check_eq("mid_rst_valid", 32'(valid_out), 32'd0);
        repeat (4) tick(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
        check_eq("mid_rst_lost", 32'(deliv.size()), 32'd0);
        check_eq("mid_rst_valid2", 32'(valid_out), 32'd0);

        // Randomized traffic
        tick(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
        val = 8'd100;
        for (int i = 0; i < 400; i++) begin
            bit r_push;
            r_push = ($urandom_range(0, 1) == 0);
            tick(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) < 3),
                 r_push, val);
            if (r_push) val = val + 8'd1;
        end
        repeat (10) tick(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
